noise_sweep_controller: RTL
===========================

NOISE_SWEEP_CONTROLLER -- requirements
Module: noise_sweep_controller

Interface
REQ-001 SHALL have parameter SAMPLES_PER_LEVEL, default 1024, giving the samples run per SNR level (legal range 1..65535).
REQ-002 SHALL have parameter LFSR_SEED, default 32'hACE12468, giving the test-pattern generator seed; a value of 0 SHALL be replaced by 32'h00000001.
REQ-003 SHALL have one clock; reset is synchronous and active-high; ports named clk and reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 start  input  1  sweep request, sampled only in IDLE.
REQ-007 abort  input  1  terminate sweep, honoured in any non-IDLE state.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse when the sweep completes normally.
REQ-010 snr_sel  output  3  channel level select: 0=40dB, 1=30dB, 2=20dB, 3=10dB, 4=0dB, 5=-10dB.
REQ-011 chan_y  output  32  clean sample to the noise channel.
REQ-012 chan_en  output  1  chan_y valid this cycle; the channel advances its noise source only when this is high.
REQ-013 chan_y_hat  input  32  noisy sample, combinational from the channel, valid in the same cycle as chan_en.
REQ-014 res_valid  output  1  per-level result available.
REQ-015 res_ready  input  1  consumer accepts the result.
REQ-016 res_level  output  3  snr_sel code the result belongs to.
REQ-017 res_errors  output  32  bit-error count for that level.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, REPORT, DONE.
REQ-019 IDLE: start=1 -> RUN next cycle; level=0, sample_cnt=0, err_acc=0, LFSR loaded with the seed.
REQ-020 RUN: chan_en=1 each cycle; chan_y=LFSR state; err_acc += popcount(chan_y XOR chan_y_hat); LFSR advances; sample_cnt increments.
REQ-021 LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h80200003); not reseeded between levels.
REQ-022 RUN -> REPORT on the cycle sample_cnt==SAMPLES_PER_LEVEL-1, with that cycle's sample included in err_acc.
REQ-023 err_acc SHALL saturate at 32'hFFFFFFFF and never wrap.
REQ-024 REPORT: res_valid=1, chan_en=0; res_level and res_errors held stable until res_valid & res_ready; the LFSR does not advance.
REQ-025 REPORT handshake with level<5 -> level+1, sample_cnt=0, err_acc=0, RUN next cycle.
REQ-026 REPORT handshake with level==5 -> DONE; DONE asserts done for exactly one cycle, then IDLE.
REQ-027 snr_sel SHALL equal level in RUN and REPORT and SHALL be 0 in IDLE and DONE.
REQ-028 start SHALL be ignored while busy=1.
REQ-029 abort=1 in RUN, REPORT or DONE -> IDLE next cycle, no done pulse, result discarded; abort has priority over every other transition, including a simultaneous handshake.
REQ-030 Latency: start accepted in cycle N gives chan_en in cycles N+1..N+S and res_valid from N+S+1 (S=SAMPLES_PER_LEVEL); with res_ready held high, a full sweep takes 6*(S+1) cycles and done is asserted in cycle N+6*(S+1)+1.
REQ-031 chan_y SHALL be 0 whenever chan_en=0.

Reset
REQ-032 reset=1 in any state -> IDLE at the next edge; busy, done, chan_en and res_valid are 0; snr_sel, chan_y, res_level and res_errors are 0; the LFSR is reloaded with the seed.
REQ-033 reset SHALL take priority over start and abort.

Verification
REQ-034 S=4, loopback (chan_y_hat=chan_y), res_ready=1 -> six results with res_level 0..5 and res_errors 0; done pulses 31 cycles after the start cycle.
REQ-035 S=4, chan_y_hat=chan_y XOR 32'h00000001 -> every res_errors=4; with XOR 32'hFFFFFFFF -> every res_errors=128.
REQ-036 S=4, res_ready low for 10 cycles in level 2 REPORT -> res_valid stays high, res_level=2 and res_errors stable, chan_en=0, no LFSR advance; next chan_y after release equals the LFSR continuation.
REQ-037 abort in the 2nd RUN cycle of level 3 -> busy=0 next cycle, no done, no res_valid; a following start restarts at level 0 with the seed pattern as the first chan_y.
REQ-038 start pulsed during RUN -> no effect; reset asserted during REPORT -> all outputs 0 next cycle.
REQ-039 LFSR_SEED=0 -> first chan_y=32'h00000001 and the second equals the one-step Galois advance of 1.

Source files
------------

// File: rtl/noise_sweep_controller.sv
// Noise sweep controller: runs an LFSR test pattern through an external noise
// channel at six SNR levels and reports the bit-error count of each level.
module noise_sweep_controller #(
    parameter int unsigned SAMPLES_PER_LEVEL = 1024,
    parameter logic [31:0] LFSR_SEED         = 32'hACE12468
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [2:0]  snr_sel,
    output logic [31:0] chan_y,
    output logic        chan_en,
    input  logic [31:0] chan_y_hat,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [2:0]  res_level,
    output logic [31:0] res_errors
);

    // An all-zero Galois LFSR would lock up, so a zero seed becomes 1.
    localparam logic [31:0] SeedEff    = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
    localparam logic [31:0] LfsrMask   = 32'h80200003;
    localparam logic [15:0] LastSample = 16'(SAMPLES_PER_LEVEL - 1);
    localparam logic [2:0]  LastLevel  = 3'd5;

    typedef enum logic [1:0] {StIdle, StRun, StReport, StDone} state_e;

    state_e      state_q, state_d;
    logic [2:0]  level_q, level_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] err_q, err_d;
    logic [31:0] lfsr_q, lfsr_d;

    logic [31:0] lfsr_next;
    logic [5:0]  pop;
    logic [32:0] err_sum;
    logic [31:0] err_sat;

    // Galois step, bit error popcount and saturating accumulate
    always_comb begin
        lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrMask : 32'd0);
        pop = 6'd0;
        for (int i = 0; i < 32; i++) begin
            pop = pop + 6'(lfsr_q[i] ^ chan_y_hat[i]);
        end
        err_sum = {1'b0, err_q} + 33'(pop);
        err_sat = err_sum[32] ? 32'hFFFFFFFF : err_sum[31:0];
    end

    // Next-state and output decode; abort overrides every non-idle transition
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        lfsr_d     = lfsr_q;
        busy       = 1'b1;
        done       = 1'b0;
        snr_sel    = 3'd0;
        chan_y     = 32'd0;
        chan_en    = 1'b0;
        res_valid  = 1'b0;
        res_level  = 3'd0;
        res_errors = 32'd0;

        unique case (state_q)
            StIdle: begin
                busy    = 1'b0;
                lfsr_d  = SeedEff;
                level_d = 3'd0;
                cnt_d   = 16'd0;
                err_d   = 32'd0;
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                snr_sel = level_q;
                chan_en = 1'b1;
                chan_y  = lfsr_q;
                err_d   = err_sat;
                lfsr_d  = lfsr_next;
                cnt_d   = cnt_q + 16'd1;
                if (cnt_q == LastSample) begin
                    state_d = StReport;
                end
            end
            StReport: begin
                snr_sel    = level_q;
                res_valid  = 1'b1;
                res_level  = level_q;
                res_errors = err_q;
                if (res_ready) begin
                    if (level_q == LastLevel) begin
                        state_d = StDone;
                    end else begin
                        level_d = level_q + 3'd1;
                        cnt_d   = 16'd0;
                        err_d   = 32'd0;
                        state_d = StRun;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Aborted results are withdrawn so a consumer never completes a handshake on them
        if (abort && (state_q != StIdle)) begin
            state_d   = StIdle;
            done      = 1'b0;
            res_valid = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            level_q <= 3'd0;
            cnt_q   <= 16'd0;
            err_q   <= 32'd0;
            lfsr_q  <= SeedEff;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            lfsr_q  <= lfsr_d;
        end
    end

endmodule
